// File: rtl/rand_pkg.sv
//------------------------------------------------------------------------------
// Module   : rand_pkg
// Desc     : Shared types, defaults and LFSR step function for rand_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rand_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP  = 2'd1,
      GRANT = 2'd2
   } state_t;

   localparam int         WIDTH_DEFAULT = 8;
   localparam logic [7:0] SEED_DEFAULT  = 8'h01;
   localparam logic [7:0] TAPS_DEFAULT  = 8'hA0;

   // Callers zero-extend to 32 bits and truncate the result back to their width,
   // so bits above the real width never feed back.
   function automatic logic [31:0] next_lfsr(input logic [31:0] value,
                                             input logic [31:0] taps);
      return {value[30:0], ^(value & taps)};
   endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_core.sv
//------------------------------------------------------------------------------
// Module   : lfsr_core
// Desc     : Fibonacci-style LFSR with seed load and zero-seed substitution.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_core
   import rand_pkg::*;
#(
   parameter int               WIDTH = WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEFAULT),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;

   assign w_next = WIDTH'(next_lfsr(32'(r_q), 32'(TAPS)));

   // A zero seed would lock the register at zero forever.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= SEED;
      end else if (load) begin
         r_q <= (load_val == '0) ? SEED : load_val;
      end else if (en) begin
         r_q <= w_next;
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/rand_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rand_arbiter
// Desc     : Round-robin arbiter sharing one LFSR among N_REQ requesters.
//            Define RAND_FREE_RUN_EN to let the LFSR also advance while idle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rand_arbiter
   import rand_pkg::*;
#(
   parameter int               N_REQ = 4,
   parameter int               WIDTH = WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEFAULT),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [WIDTH-1:0] rand_data,
   output logic             rand_valid,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic             busy
);

   localparam int               c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [c_idx_w:0] c_n_req = (c_idx_w + 1)'(N_REQ);

   state_t               r_state;
   logic [c_idx_w-1:0]   r_winner;
   logic [c_idx_w-1:0]   r_rr;

   logic [WIDTH-1:0]     w_lfsr;
   logic [WIDTH-1:0]     w_lfsr_step;
   logic                 w_lfsr_en;
   logic                 w_lfsr_load;
   logic [2*N_REQ-1:0]   w_req2;
   logic [N_REQ-1:0]     w_rot;
   logic                 w_found;
   logic [c_idx_w-1:0]   w_offset;
   logic [c_idx_w:0]     w_sum;
   logic [c_idx_w-1:0]   w_winner;
   logic [c_idx_w-1:0]   w_rr_next;
   logic [N_REQ-1:0]     w_gnt_onehot;

   // Rotate requests so the round-robin pointer lands on bit 0, then take the lowest set bit.
   assign w_req2 = {req, req};
   assign w_rot  = N_REQ'(w_req2 >> r_rr);

   always_comb begin
      w_found  = 1'b0;
      w_offset = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_found  = 1'b1;
            w_offset = c_idx_w'(i);
         end
      end
   end

   assign w_sum        = {1'b0, r_rr} + {1'b0, w_offset};
   assign w_winner     = (w_sum >= c_n_req) ? c_idx_w'(w_sum - c_n_req) : c_idx_w'(w_sum);
   assign w_rr_next    = (r_winner == c_idx_w'(N_REQ - 1)) ? '0 : r_winner + c_idx_w'(1);
   assign w_gnt_onehot = N_REQ'(1) << r_winner;

   assign w_lfsr_load = (r_state == IDLE) && seed_load;
`ifdef RAND_FREE_RUN_EN
   assign w_lfsr_en   = (r_state == STEP) || ((r_state == IDLE) && !seed_load);
`else
   assign w_lfsr_en   = (r_state == STEP);
`endif

   // The value the LFSR takes at the end of STEP, registered alongside the grant.
   assign w_lfsr_step = WIDTH'(next_lfsr(32'(w_lfsr), 32'(TAPS)));

   lfsr_core #(
      .WIDTH (WIDTH),
      .SEED  (SEED),
      .TAPS  (TAPS)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .en       (w_lfsr_en),
      .load     (w_lfsr_load),
      .load_val (seed_in),
      .q        (w_lfsr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_winner   <= '0;
         r_rr       <= '0;
         gnt        <= '0;
         rand_valid <= 1'b0;
         rand_data  <= '0;
         busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!seed_load && w_found) begin
                  r_winner <= w_winner;
                  busy     <= 1'b1;
                  r_state  <= STEP;
               end
            end
            STEP: begin
               gnt        <= w_gnt_onehot;
               rand_valid <= 1'b1;
               rand_data  <= w_lfsr_step;
               r_state    <= GRANT;
            end
            GRANT: begin
               gnt        <= '0;
               rand_valid <= 1'b0;
               busy       <= 1'b0;
               r_rr       <= w_rr_next;
               r_state    <= IDLE;
            end
            default: begin
               gnt        <= '0;
               rand_valid <= 1'b0;
               busy       <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rand_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_rand_arbiter
// Desc     : Self-checking bench for rand_arbiter (default build, N_REQ=4, WIDTH=8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rand_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [W-1:0] rand_data;
   logic         rand_valid;
   logic         seed_load;
   logic [W-1:0] seed_in;
   logic         busy;

   always #5 clk = ~clk;

   rand_arbiter #(
      .N_REQ (N),
      .WIDTH (W),
      .SEED  (8'h01),
      .TAPS  (8'hA0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .gnt        (gnt),
      .rand_data  (rand_data),
      .rand_valid (rand_valid),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .busy       (busy)
   );

   typedef struct {
      logic         r;
      logic [N-1:0] q;
      logic         sl;
      logic [W-1:0] si;
      logic [N-1:0] g;
      logic         v;
      logic         b;
      logic [W-1:0] d;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state: plain integers, advanced once per clock edge
   int m_lfsr, m_rr, m_phase, m_win, m_data;

   function automatic logic [N+W+1:0] outs();
      return {gnt, rand_valid, busy, rand_data};
   endfunction

   task automatic check(input string name, input logic [N+W+1:0] act, input logic [N+W+1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got gnt=%b valid=%b busy=%b data=%h, expected gnt=%b valid=%b busy=%b data=%h",
                  name, act[N+W+1:W+2], act[W+1], act[W], act[W-1:0],
                  exp[N+W+1:W+2], exp[W+1], exp[W], exp[W-1:0]);
      end
   endtask

   task automatic add(input logic r, input logic [N-1:0] q, input logic sl, input logic [W-1:0] si,
                      input logic [N-1:0] g, input logic v, input logic b, input logic [W-1:0] d);
      tbl.push_back('{r: r, q: q, sl: sl, si: si, g: g, v: v, b: b, d: d});
   endtask

   task automatic apply(input logic r, input logic [N-1:0] q, input logic sl, input logic [W-1:0] si);
      rst       = r;
      req       = q;
      seed_load = sl;
      seed_in   = si;
      @(posedge clk);
      #1;
   endtask

   function automatic int lfsr_next(input int v);
      int fb;
      fb = $countones(v & 'hA0) % 2;
      return ((v * 2) % 256) + fb;
   endfunction

   task automatic model_edge(input logic r, input logic [N-1:0] q, input logic sl, input logic [W-1:0] si);
      if (r) begin
         m_lfsr = 1; m_rr = 0; m_phase = 0; m_win = 0; m_data = 0;
      end else if (m_phase == 0) begin
         if (sl) begin
            m_lfsr = (si == 0) ? 1 : int'(si);
         end else if (q != 0) begin
            for (int k = N - 1; k >= 0; k--)
               if (q[(m_rr + k) % N]) m_win = (m_rr + k) % N;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_lfsr  = lfsr_next(m_lfsr);
         m_data  = m_lfsr;
         m_phase = 2;
      end else begin
         m_rr    = (m_win + 1) % N;
         m_phase = 0;
      end
   endtask

   function automatic logic [N+W+1:0] model_exp();
      logic [N-1:0] g;
      g = (m_phase == 2) ? N'(1 << m_win) : '0;
      return {g, m_phase == 2, m_phase != 0, W'(m_data)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic r, sl;
      logic [N-1:0] q;
      logic [W-1:0] si;

      // Single requester: 02, 04, 08
      add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h00);
      add(0, 4'h1, 0, 8'h00, 4'h0, 0, 1, 8'h00);
      add(0, 4'h1, 0, 8'h00, 4'h1, 1, 1, 8'h02);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h02);
      add(0, 4'h1, 0, 8'h00, 4'h0, 0, 1, 8'h02);
      add(0, 4'h1, 0, 8'h00, 4'h1, 1, 1, 8'h04);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h04);
      add(0, 4'h1, 0, 8'h00, 4'h0, 0, 1, 8'h04);
      add(0, 4'h1, 0, 8'h00, 4'h1, 1, 1, 8'h08);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h08);
      // All requesters: round-robin order, one grant every 3 cycles
      add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h00);
      add(0, 4'hF, 0, 8'h00, 4'h0, 0, 1, 8'h00);
      add(0, 4'hF, 0, 8'h00, 4'h1, 1, 1, 8'h02);
      add(0, 4'hE, 0, 8'h00, 4'h0, 0, 0, 8'h02);
      add(0, 4'hF, 0, 8'h00, 4'h0, 0, 1, 8'h02);
      add(0, 4'hF, 0, 8'h00, 4'h2, 1, 1, 8'h04);
      add(0, 4'hD, 0, 8'h00, 4'h0, 0, 0, 8'h04);
      add(0, 4'hF, 0, 8'h00, 4'h0, 0, 1, 8'h04);
      add(0, 4'hF, 0, 8'h00, 4'h4, 1, 1, 8'h08);
      add(0, 4'hB, 0, 8'h00, 4'h0, 0, 0, 8'h08);
      add(0, 4'hF, 0, 8'h00, 4'h0, 0, 1, 8'h08);
      add(0, 4'hF, 0, 8'h00, 4'h8, 1, 1, 8'h10);
      add(0, 4'h7, 0, 8'h00, 4'h0, 0, 0, 8'h10);
      add(0, 4'hF, 0, 8'h00, 4'h0, 0, 1, 8'h10);
      add(0, 4'hF, 0, 8'h00, 4'h1, 1, 1, 8'h20);
      add(0, 4'hE, 0, 8'h00, 4'h0, 0, 0, 8'h20);
      // Seed loads: 00 -> substitute, 80 -> 01, 20 -> 41
      add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h00);
      add(0, 4'h0, 1, 8'h00, 4'h0, 0, 0, 8'h00);
      add(0, 4'h1, 0, 8'h00, 4'h0, 0, 1, 8'h00);
      add(0, 4'h1, 0, 8'h00, 4'h1, 1, 1, 8'h02);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h02);
      add(0, 4'h0, 1, 8'h80, 4'h0, 0, 0, 8'h02);
      add(0, 4'h1, 0, 8'h00, 4'h0, 0, 1, 8'h02);
      add(0, 4'h1, 0, 8'h00, 4'h1, 1, 1, 8'h01);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h01);
      add(0, 4'h0, 1, 8'h20, 4'h0, 0, 0, 8'h01);
      add(0, 4'h1, 0, 8'h00, 4'h0, 0, 1, 8'h01);
      add(0, 4'h1, 0, 8'h00, 4'h1, 1, 1, 8'h41);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h41);
      // Seed load beats a simultaneous request
      add(0, 4'h2, 1, 8'h80, 4'h0, 0, 0, 8'h41);
      add(0, 4'h2, 0, 8'h00, 4'h0, 0, 1, 8'h41);
      add(0, 4'h2, 0, 8'h00, 4'h2, 1, 1, 8'h01);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h01);
      // Seed loads while busy are ignored
      add(0, 4'h4, 0, 8'h00, 4'h0, 0, 1, 8'h01);
      add(0, 4'h4, 1, 8'h55, 4'h4, 1, 1, 8'h02);
      add(0, 4'h0, 1, 8'hAA, 4'h0, 0, 0, 8'h02);
      add(0, 4'h8, 0, 8'h00, 4'h0, 0, 1, 8'h02);
      add(0, 4'h8, 0, 8'h00, 4'h8, 1, 1, 8'h04);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h04);
      // Withdrawn request still granted; pointer then starts at bit 3
      add(0, 4'h4, 0, 8'h00, 4'h0, 0, 1, 8'h04);
      add(0, 4'h0, 0, 8'h00, 4'h4, 1, 1, 8'h08);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h08);
      add(0, 4'hF, 0, 8'h00, 4'h0, 0, 1, 8'h08);
      add(0, 4'hF, 0, 8'h00, 4'h8, 1, 1, 8'h10);
      add(0, 4'h0, 0, 8'h00, 4'h0, 0, 0, 8'h10);

      rst = 1'b1; req = '0; seed_load = 1'b0; seed_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", outs(), '0);

      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].q, tbl[i].sl, tbl[i].si);
         check($sformatf("vec%0d", i), outs(), {tbl[i].g, tbl[i].v, tbl[i].b, tbl[i].d});
      end

      // Asynchronous reset in the middle of a GRANT cycle
      apply(1, 4'h0, 0, 8'h00);
      apply(0, 4'h1, 0, 8'h00);
      apply(0, 4'h1, 0, 8'h00);
      check("pre_rst_grant", outs(), {4'h1, 1'b1, 1'b1, 8'h02});
      #2 rst = 1'b1;
      #1 check("async_rst_grant", outs(), '0);
      @(posedge clk); #1;
      apply(0, 4'h1, 0, 8'h00);
      check("post_rst_step", outs(), {4'h0, 1'b0, 1'b1, 8'h00});
      apply(0, 4'h1, 0, 8'h00);
      check("post_rst_grant", outs(), {4'h1, 1'b1, 1'b1, 8'h02});
      apply(0, 4'h0, 0, 8'h00);
      // Reset during STEP drops the pending grant
      apply(0, 4'h2, 0, 8'h00);
      check("pre_rst_step", outs(), {4'h0, 1'b0, 1'b1, 8'h02});
      #2 rst = 1'b1;
      #1 check("async_rst_step", outs(), '0);
      apply(0, 4'h0, 0, 8'h00);
      check("lost_grant", outs(), '0);

      // Randomized traffic against the reference model
      apply(1, 4'h0, 0, 8'h00);
      model_edge(1, 4'h0, 0, 8'h00);
      for (int c = 0; c < 600; c++) begin
         r  = ($urandom_range(0, 149) == 0);
         q  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) q = '0;
         sl = ($urandom_range(0, 7) == 0);
         si = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         apply(r, q, sl, si);
         model_edge(r, q, sl, si);
         check($sformatf("rand%0d", c), outs(), model_exp());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rand_arbiter.md
Name: rand_arbiter

Overview:
- Shares one 8-bit LFSR random source among N_REQ requesters using round-robin arbitration.
- Each accepted request advances the LFSR and returns a fresh value to the winner with a one-cycle grant pulse.
- Handles seed loading and zero-seed protection.
- Sits between game/test logic blocks and the shared random generator on the FPGA.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, LFSR and output data width.
- SEED, 8'h01, reset seed and zero-seed substitute (must be nonzero).
- TAPS, 8'hA0, feedback mask; feedback bit = XOR of lfsr bits selected by TAPS (default: bit7 ^ bit5); shift left, feedback into bit0.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until its gnt bit pulses.
- gnt  out  N_REQ  one-hot grant, single-cycle pulse.
- rand_data  out  WIDTH  random value, valid while rand_valid=1.
- rand_valid  out  1  high exactly in the gnt cycle.
- seed_load  in  1  load-seed strobe, accepted only when busy=0.
- seed_in  in  WIDTH  seed value.
- busy  out  1  high in STEP and GRANT states.

Behaviour:
- Reset (async): state=IDLE, lfsr=SEED, rr pointer=0, gnt=0, rand_valid=0, rand_data=0, busy=0.
- State IDLE:
  - If seed_load=1: lfsr <= (seed_in==0 ? SEED : seed_in); stay IDLE. Seed load has priority over req in the same cycle; req is re-evaluated next cycle.
  - Else if req!=0: latch winner, go to STEP.
- Winner selection: first set bit of req searching from rr pointer upward, wrapping modulo N_REQ.
- State STEP: lfsr advances one step; go to GRANT.
- State GRANT: gnt[winner]=1, rand_valid=1, rand_data=current lfsr (the post-step value). Set rr pointer = (winner+1) mod N_REQ. Go to IDLE.
- Latency and throughput: req seen in IDLE at cycle t gives the grant at t+2. The minimum period between grants is 3 cycles.
- Dropped request: if the winner drops req after it is latched, the grant is still issued; the value is consumed and discarded.
- seed_load outside IDLE: ignored, not queued.
- rand_data holds its last value when rand_valid=0.
- LFSR state 0 is unreachable: the reset seed is nonzero and zero seeds are substituted.
- Reset mid-operation (any state): immediate return to the reset values; any pending grant is lost.

Optional Feature:
- Macro: RAND_FREE_RUN_EN.
- Defined: the LFSR also advances every cycle while in IDLE (except on seed-load cycles), so values depend on request timing.
- Undefined: the LFSR advances only in STEP, so the grant sequence is deterministic from the seed.

Decomposition:
- Package rand_pkg contains:
  - state enum {IDLE, STEP, GRANT};
  - WIDTH default;
  - SEED and TAPS defaults;
  - a next_lfsr function (shift plus masked-XOR feedback).
- Sub-module lfsr_core:
  - ports clk, rst, en, load, load_val, q;
  - zero-seed substitution done inside lfsr_core;
  - rand_arbiter instantiates one lfsr_core.

Test Plan (free-run undefined, defaults):
- Reset: assert rst mid-cycle -> gnt=0, rand_valid=0, busy=0, rand_data=00 immediately; first grant afterwards returns 02.
- Single requester: req=0001 held, dropped after each gnt -> gnt=0001 at t+2 with data 02, next pass 04, then 08.
- All requesters: req=1111, each bit dropped on its gnt and re-raised 1 cycle later -> gnt order 0001,0010,0100,1000,0001, spaced 3 cycles, data 02,04,08,10,20.
- Seed load: seed_in=00 -> next grant returns 02 (SEED substituted); seed_in=80 -> next grant returns 01; seed_in=20 -> next grant returns 41.
- Simultaneous seed_load=1 (seed_in=80) and req=0010 in IDLE -> seed loaded first, then gnt=0010 at t+3 with data 01. seed_load pulsed while busy=1 -> no effect on the subsequent sequence.
- Withdrawn request: req=0100 for a single cycle -> gnt=0100 still pulses 2 cycles later; rr pointer then starts from bit 3.
